// File: rtl/out_port_fifo_if.sv
// Bundle for the CPU OUT-port FIFO. The write strobe comes from the control unit.
// The head-of-queue handshake and the status signals go to the external consumer.
interface out_port_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             ext_valid;
  logic [WIDTH-1:0] ext_data;
  logic             ext_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             ovf_clr;

  // The environment side: the control unit writes and the consumer drains.
  modport master (
    output out_valid, out_data, ext_ready, ovf_clr,
    input  ext_valid, ext_data, count, full, empty, ovf
  );

  // The FIFO side.
  modport slave (
    input  out_valid, out_data, ext_ready, ovf_clr,
    output ext_valid, ext_data, count, full, empty, ovf
  );
endinterface

// File: rtl/out_port_fifo.sv
// First-word-fall-through FIFO that sits between the CPU OUT instruction and an external consumer.
// Define OUT_PORT_OVF_EN to build the sticky overflow flag (ovf/ovf_clr).
module out_port_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  out_port_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // The control unit cannot be stalled. A word that arrives while the FIFO is full is
  // accepted only if the head leaves in the same cycle.
  assign pop  = !empty && bus.ext_ready;
  assign push = bus.out_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every update in this block reads pre-edge values.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Emptying the pointers and the count discards the entries.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= bus.out_data;
  end

  // The head word is taken straight from registered state. A push into an empty FIFO
  // becomes visible one cycle later.
  assign bus.ext_valid = !empty;
  assign bus.ext_data  = mem[rd_ptr];
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;

`ifdef OUT_PORT_OVF_EN
  logic ovf_q;
  logic drop;

  // A dropped word wins over a simultaneous clear, so that no overflow event goes unreported.
  assign drop = bus.out_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst_n)            ovf_q <= 1'b0;
    else if (drop)         ovf_q <= 1'b1;
    else if (bus.ovf_clr)  ovf_q <= 1'b0;
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = bus.ovf_clr;
  assign bus.ovf        = 1'b0;
`endif
endmodule

// File: doc/out_port_fifo.md
OUT_PORT_FIFO -- requirements
Module: out_port_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width matching the machine word.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port out_valid  input  1  write strobe, driven by the control unit's output_valid during an OUT instruction.
REQ-006 SHALL have port out_data  input  WIDTH  word to write, the register-file operand of the OUT instruction.
REQ-007 SHALL have port ext_valid  output  1  head entry available to the external consumer.
REQ-008 SHALL have port ext_data  output  WIDTH  head entry value.
REQ-009 SHALL have port ext_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have ports full and empty  output  1 each  count==DEPTH and count==0.
REQ-012 SHALL have ports ovf  output  1  sticky overflow flag, and ovf_clr  input  1  clears ovf.

Function
REQ-013 SHALL define push = out_valid && (!full || pop) and pop = ext_valid && ext_ready.
REQ-014 SHALL, on push, write out_data to mem[wr_ptr] and advance wr_ptr modulo DEPTH.
REQ-015 SHALL, on pop, advance rd_ptr modulo DEPTH.
REQ-016 SHALL update count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-017 SHALL present first-word-fall-through output: ext_valid = !empty, ext_data = mem[rd_ptr], both from registered state.
REQ-018 SHALL have write-to-visible latency of one cycle: a push at edge N raises ext_valid after edge N; there is no combinational bypass from out_data to ext_data.
REQ-019 SHALL, when empty and out_valid is high, push only; pop is impossible because ext_valid is low.
REQ-020 SHALL, when full with out_valid and pop in the same cycle, perform both; count stays DEPTH.
REQ-021 SHALL, when full with out_valid and no pop, drop out_data and leave the pointers and count unchanged.
REQ-022 SHALL hold ext_data stable while ext_valid is high and ext_ready is low, whatever pushes occur.
REQ-023 SHALL treat ext_ready as a don't-care while ext_valid is low.
REQ-024 SHALL never stall the control unit: out_valid is a one-cycle fire-and-forget strobe with no ready back-pressure.

Reset
REQ-025 SHALL, when rst_n is low at a rising clk edge, clear wr_ptr, rd_ptr and count to 0 and ovf to 0.
REQ-026 SHALL drive these values from the first edge after rst_n goes low: ext_valid=0, empty=1, full=0, count=0, ovf=0.
REQ-027 SHALL, on reset mid-operation, discard all queued entries; memory contents need not be cleared.
REQ-028 SHALL give reset priority over a simultaneous push, pop and ovf_clr.

Configuration
REQ-029 SHALL implement overflow detection only when macro OUT_PORT_OVF_EN is defined.
REQ-030 SHALL, with OUT_PORT_OVF_EN defined, set ovf on every REQ-021 drop; ovf_clr clears it the next cycle; a drop in the same cycle as ovf_clr leaves ovf=1.
REQ-031 SHALL, without OUT_PORT_OVF_EN, tie ovf to 0, ignore ovf_clr and infer no ovf register; all other behaviour is identical.

Verification
REQ-032 SHALL cover this scenario: after reset, push 0x1234, ext_ready=0 -> next cycle ext_valid=1, ext_data=0x1234, count=1.
REQ-033 SHALL cover this scenario: push 0x0001..0x0008 with ext_ready=0 (DEPTH=8) -> full=1, count=8; then ext_ready=1 -> outputs 0x0001..0x0008 in order, then empty=1.
REQ-034 SHALL cover this scenario: full FIFO, push 0xBEEF with ext_ready=0 -> count=8, 0xBEEF never output, ovf=1 (macro on) or 0 (macro off).
REQ-035 SHALL cover this scenario: full FIFO, push 0xCAFE with ext_ready=1 in the same cycle -> count stays 8 and 0xCAFE is the 8th word output after the current head.
REQ-036 SHALL cover this scenario: 3 entries queued, rst_n=0 for one edge -> ext_valid=0, count=0; a new push 0x00AA is then output first.
REQ-037 SHALL cover this scenario: 20 push/pop cycles at count=1 -> pointers wrap past 7 with no data loss and in-order values.
